// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch tick core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;
endpackage

// File: rtl/tick_sync_edge.sv
// tick_sync_edge: synchronise a slow square wave and emit a one-cycle tick per rising edge
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  // shift the input through the synchroniser and remember the last synced level
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end
  assign tick = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/stopwatch_tick_core.sv
// stopwatch_tick_core: start/pause/clear MM:SS BCD stopwatch with display scan index
module stopwatch_tick_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       clk_1kHz,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_bcd
);
  localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN_TENS);
  state_t state;
  logic tick_1hz, tick_1khz;
  logic count, so_wrap, st_wrap, mo_wrap, mt_wrap;
  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .async_in(clk_1Hz), .tick(tick_1hz)
  );
  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1khz (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .async_in(clk_1kHz), .tick(tick_1khz)
  );
  assign count   = (state == RUN) && tick_1hz;
  assign so_wrap = sec_ones == BCD_MAX;
  assign st_wrap = so_wrap && sec_tens == SEC_TENS_MAX;
  assign mo_wrap = st_wrap && min_ones == BCD_MAX;
  assign mt_wrap = mo_wrap && min_tens == MIN_TENS_MAX;
  // run control: clear beats start_stop in PAUSE, clear is ignored while running
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_stop) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (start_stop) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        PAUSE: if (clear) begin
          state   <= IDLE;
          running <= 1'b0;
        end else if (start_stop) begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end
  // ripple-carry BCD count on 1Hz ticks seen in RUN, zeroed by clear from PAUSE
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      rollover <= 1'b0;
    end else if (state == PAUSE && clear) begin
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= count && mt_wrap;
      if (count) sec_ones <= so_wrap ? '0 : sec_ones + 4'd1;
      if (count && so_wrap) sec_tens <= st_wrap ? '0 : sec_tens + 4'd1;
      if (count && st_wrap) min_ones <= mo_wrap ? '0 : min_ones + 4'd1;
      if (count && mo_wrap) min_tens <= mt_wrap ? '0 : min_tens + 4'd1;
    end
  end
  // display scan index advances on every 1kHz tick regardless of state
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) digit_sel <= DIG_SEC_ONES;
    else if (tick_1khz) digit_sel <= digit_sel + 2'd1;
  end
  assign digit_bcd = digit_sel == DIG_SEC_ONES ? sec_ones :
                     digit_sel == DIG_SEC_TENS ? sec_tens :
                     digit_sel == DIG_MIN_ONES ? min_ones : min_tens;
endmodule

// File: tb/tb_stopwatch_tick_core.sv
// tb_stopwatch_tick_core: directed, table-driven check of the stopwatch tick core
module tb_stopwatch_tick_core;
  logic clk_25MHz = 1'b0;
  logic rst_n = 1'b0;
  logic clk_1Hz = 1'b0;
  logic clk_1kHz = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, digit_bcd;
  logic running, rollover;
  logic [1:0] digit_sel;
  logic [15:0] cnt;
  int errors = 0;
  int checks = 0;
  int roll_cycles = 0;
  logic [1:0] sel_m = 2'd0;
  typedef struct {
    logic ss;
    logic clr;
    int edges;
    logic exp_run;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[5];
  logic [3:0] bcd_exp[4];

  stopwatch_tick_core dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .clk_1Hz(clk_1Hz), .clk_1kHz(clk_1kHz),
    .start_stop(start_stop), .clear(clear), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .rollover(rollover),
    .digit_sel(digit_sel), .digit_bcd(digit_bcd)
  );

  assign cnt = {min_tens, min_ones, sec_tens, sec_ones};

  initial forever #20 clk_25MHz = ~clk_25MHz;

  always @(negedge clk_25MHz) if (rollover) roll_cycles++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic ss, input logic clr);
    @(negedge clk_25MHz);
    start_stop = ss;
    clear = clr;
    @(negedge clk_25MHz);
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic sec_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25MHz);
      clk_1Hz = 1'b1;
      repeat (4) @(negedge clk_25MHz);
      clk_1Hz = 1'b0;
      repeat (4) @(negedge clk_25MHz);
    end
  endtask

  task automatic khz_edge();
    @(negedge clk_25MHz);
    clk_1kHz = 1'b1;
    repeat (4) @(negedge clk_25MHz);
    clk_1kHz = 1'b0;
    repeat (4) @(negedge clk_25MHz);
    sel_m = sel_m + 2'd1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5, 1'b1, 16'h0005};
    tbl[1] = '{1'b0, 1'b1, 2, 1'b1, 16'h0007};
    tbl[2] = '{1'b1, 1'b0, 0, 1'b0, 16'h0007};
    tbl[3] = '{1'b0, 1'b0, 3, 1'b0, 16'h0007};
    tbl[4] = '{1'b1, 1'b0, 0, 1'b1, 16'h0007};
    bcd_exp[0] = 4'd4;
    bcd_exp[1] = 4'd3;
    bcd_exp[2] = 4'd2;
    bcd_exp[3] = 4'd1;
    repeat (3) @(negedge clk_25MHz);
    chk("reset_cnt", 32'(cnt), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_rollover", 32'(rollover), 32'h0);
    chk("reset_sel", 32'(digit_sel), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      khz_edge();
      chk("scan_sel", 32'(digit_sel), 32'((i + 1) % 4));
      chk("scan_bcd_zero", 32'(digit_bcd), 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      pulse(tbl[i].ss, tbl[i].clr);
      sec_edges(tbl[i].edges);
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].exp_cnt));
    end
    @(negedge clk_25MHz);
    clk_1Hz = 1'b1;
    @(negedge clk_25MHz);
    @(negedge clk_25MHz);
    start_stop = 1'b1;
    @(negedge clk_25MHz);
    start_stop = 1'b0;
    chk("tick_with_stop_cnt", 32'(cnt), 32'h0008);
    chk("tick_with_stop_running", 32'(running), 32'h0);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_25MHz);
    sec_edges(2);
    chk("pause_hold_cnt", 32'(cnt), 32'h0008);
    pulse(1'b1, 1'b1);
    chk("pause_clear_wins_cnt", 32'(cnt), 32'h0);
    chk("pause_clear_wins_running", 32'(running), 32'h0);
    sec_edges(1);
    chk("idle_no_count", 32'(cnt), 32'h0);
    pulse(1'b1, 1'b0);
    @(negedge clk_25MHz);
    clk_1Hz = 1'b1;
    @(posedge clk_25MHz); #1;
    chk("lat_edge1", 32'(cnt), 32'h0);
    @(posedge clk_25MHz); #1;
    chk("lat_edge2", 32'(cnt), 32'h0);
    @(posedge clk_25MHz); #1;
    chk("lat_edge3", 32'(cnt), 32'h0001);
    repeat (2) @(negedge clk_25MHz);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_25MHz);
    sec_edges(58);
    chk("cnt_0059", 32'(cnt), 32'h0059);
    sec_edges(1);
    chk("cnt_0100", 32'(cnt), 32'h0100);
    sec_edges(3539);
    chk("cnt_5959", 32'(cnt), 32'h5959);
    chk("no_early_rollover", 32'(roll_cycles), 32'h0);
    sec_edges(1);
    chk("wrap_cnt", 32'(cnt), 32'h0);
    chk("rollover_one_cycle", 32'(roll_cycles), 32'h1);
    sec_edges(1);
    chk("after_wrap_cnt", 32'(cnt), 32'h0001);
    chk("rollover_single", 32'(roll_cycles), 32'h1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    sec_edges(754);
    pulse(1'b1, 1'b0);
    chk("cnt_1234", 32'(cnt), 32'h1234);
    for (int i = 0; i < 4; i++) begin
      chk("mux_sel", 32'(digit_sel), 32'(sel_m));
      chk("mux_bcd", 32'(digit_bcd), 32'(bcd_exp[sel_m]));
      khz_edge();
    end
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    sec_edges(201);
    chk("cnt_0321", 32'(cnt), 32'h0321);
    @(negedge clk_25MHz);
    #7 rst_n = 1'b0;
    clk_1Hz = 1'b1;
    clk_1kHz = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    chk("async_rst_running", 32'(running), 32'h0);
    chk("async_rst_sel", 32'(digit_sel), 32'h0);
    @(negedge clk_25MHz);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_25MHz);
    chk("release_one_tick_sel", 32'(digit_sel), 32'h1);
    chk("release_cnt", 32'(cnt), 32'h0);
    chk("release_running", 32'(running), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
